// File: rtl/uob_output_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uob_output_arbiter_pkg
// Description : Shared constants, FSM state encodings and width helper for
//               the UOB output arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uob_output_arbiter_pkg;

    // Width of one UOB output word toward the host.
    localparam int UNIT_OUTPUT_WIDTH = 32;

    // Index of the most significant bit needed to hold 'value'.
    function automatic int msb(input int value);
        if (value <= 1) begin
            return 0;
        end
        return $clog2(value + 1) - 1;
    endfunction

    localparam logic [2:0] STATE_INIT  = 3'd0;
    localparam logic [2:0] STATE_IDLE  = 3'd1;
    localparam logic [2:0] STATE_HDR   = 3'd2;
    localparam logic [2:0] STATE_DATA  = 3'd3;
    localparam logic [2:0] STATE_TRAIL = 3'd4;
    localparam logic [2:0] STATE_DRAIN = 3'd5;

    typedef enum logic [2:0] {
        ST_INIT  = STATE_INIT,
        ST_IDLE  = STATE_IDLE,
        ST_HDR   = STATE_HDR,
        ST_DATA  = STATE_DATA,
        ST_TRAIL = STATE_TRAIL,
        ST_DRAIN = STATE_DRAIN
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uob_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uob_output_arbiter_if
// Description : UOB read side plus host-facing packet stream of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uob_output_arbiter_if
    import uob_output_arbiter_pkg::*;
#(
    parameter int N_UNITS   = 4,
    parameter int OUT_WIDTH = UNIT_OUTPUT_WIDTH,
    parameter int UNIT_MSB  = msb(N_UNITS - 1)
);

    logic [N_UNITS-1:0]           unit_empty;
    logic [N_UNITS-1:0]           unit_rd_en;
    logic [N_UNITS*OUT_WIDTH-1:0] unit_dout;
    logic                         space;
    logic [OUT_WIDTH-1:0]         dout;
    logic                         wr_en;
    logic                         pkt_start;
    logic                         pkt_end;
    logic [UNIT_MSB:0]            unit_id;
    logic                         err_header;

    modport master (
        input  unit_empty, unit_dout, space,
        output unit_rd_en, dout, wr_en, pkt_start, pkt_end, unit_id, err_header
    );

    modport slave (
        output unit_empty, unit_dout, space,
        input  unit_rd_en, dout, wr_en, pkt_start, pkt_end, unit_id, err_header
    );

endinterface
`default_nettype wire

// File: rtl/uob_output_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : uob_output_arbiter_rr_select
// Description : Combinational round-robin picker. Searches the request vector
//               starting one past the pointer, wrapping, and returns a one-hot
//               grant plus the granted index.
// Revision    : 1.0 - initial release
// ============================================================================
module uob_output_arbiter_rr_select
    import uob_output_arbiter_pkg::*;
#(
    parameter int N_UNITS  = 4,
    parameter int UNIT_MSB = msb(N_UNITS - 1)
) (
    input  wire logic [N_UNITS-1:0]  req,
    input  wire logic [UNIT_MSB:0]   ptr,
    output logic      [N_UNITS-1:0]  grant,
    output logic      [UNIT_MSB:0]   idx,
    output logic                     valid
);

    localparam int UNIT_W = UNIT_MSB + 1;

    logic [UNIT_MSB:0] w_cand;

    // First requester at offsets 1..N_UNITS from the pointer wins; the pointer
    // itself is visited last so the previous winner has lowest priority.
    always_comb begin
        grant  = '0;
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int off = 1; off <= N_UNITS; off++) begin
            w_cand = UNIT_W'((int'(ptr) + off) % N_UNITS);
            if (!valid && req[w_cand]) begin
                valid         = 1'b1;
                idx           = w_cand;
                grant[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uob_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uob_output_arbiter
// Description : Round-robin arbiter that starts a UOB read only when the host
//               path can take a whole packet, validates the header and
//               forwards the fixed-length packet with framing and unit tag.
// Revision    : 1.0 - initial release
// ============================================================================
module uob_output_arbiter
    import uob_output_arbiter_pkg::*;
#(
    parameter int N_UNITS     = 4,
    parameter int UNIT_MSB    = msb(N_UNITS - 1),
    parameter int OUT_WIDTH   = UNIT_OUTPUT_WIDTH,
    parameter int OUT_N_WORDS = 40,
    parameter int INIT_GUARD  = OUT_N_WORDS + 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    uob_output_arbiter_if.master  bus
);

    localparam int UNIT_W  = UNIT_MSB + 1;
    localparam int CNT_W   = msb(OUT_N_WORDS) + 1;
    localparam int GUARD_W = msb(INIT_GUARD) + 1;

    localparam logic [CNT_W-1:0]     DATA_LAST  = CNT_W'(OUT_N_WORDS - 1);
    localparam logic [CNT_W-1:0]     DRAIN_LAST = CNT_W'(OUT_N_WORDS);
    localparam logic [GUARD_W-1:0]   GUARD_LAST = GUARD_W'(INIT_GUARD - 1);
    localparam logic [OUT_WIDTH-1:0] HEADER     = {OUT_WIDTH{1'b1}};

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_count, w_count_next;
    logic [GUARD_W-1:0]  r_guard, w_guard_next;
    logic [UNIT_MSB:0]   r_sel,   w_sel_next;
    logic [UNIT_MSB:0]   r_rr,    w_rr_next;
    logic                r_err,   w_err_next;

    logic [N_UNITS-1:0]  w_rd_en;
    logic                w_fwd_valid;
    logic                w_fwd_start;
    logic                w_fwd_end;

    logic [OUT_WIDTH-1:0] r_dout;
    logic                 r_wr_en;
    logic                 r_pkt_start;
    logic                 r_pkt_end;
    logic [UNIT_MSB:0]    r_unit_id;

    logic [N_UNITS-1:0]   w_pick_grant;
    logic [UNIT_MSB:0]    w_pick_idx;
    logic                 w_pick_valid;

    logic [OUT_WIDTH-1:0] w_words [N_UNITS];
    logic [OUT_WIDTH-1:0] w_word;

    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unpack
        assign w_words[gi] = bus.unit_dout[gi*OUT_WIDTH +: OUT_WIDTH];
    end

    // The stream of the granted unit is the only one ever looked at.
    assign w_word = w_words[r_sel];

    uob_output_arbiter_rr_select #(
        .N_UNITS  (N_UNITS),
        .UNIT_MSB (UNIT_MSB)
    ) u_rr_select (
        .req   (~bus.unit_empty),
        .ptr   (r_rr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Next-state, counter and forwarding decisions for the packet sequencer.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_guard_next = r_guard;
        w_sel_next   = r_sel;
        w_rr_next    = r_rr;
        w_err_next   = r_err;
        w_rd_en      = '0;
        w_fwd_valid  = 1'b0;
        w_fwd_start  = 1'b0;
        w_fwd_end    = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Lets a stream that survived an arbiter-only reset run out.
                if (r_guard == GUARD_LAST) begin
                    w_guard_next = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_guard_next = r_guard + GUARD_W'(1);
                end
            end
            ST_IDLE: begin
                // A started stream cannot be paused, so room must exist first.
                // No read is issued while reset is pending.
                if (bus.space && w_pick_valid && !rst) begin
                    w_rd_en      = w_pick_grant;
                    w_sel_next   = w_pick_idx;
                    w_rr_next    = w_pick_idx;
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                w_count_next = '0;
                if (w_word == HEADER) begin
                    w_fwd_valid  = 1'b1;
                    w_fwd_start  = 1'b1;
                    w_state_next = ST_DATA;
                end else begin
                    w_err_next   = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DATA: begin
                w_fwd_valid = 1'b1;
                if (r_count == DATA_LAST) begin
                    w_fwd_end    = 1'b1;
                    w_count_next = '0;
                    w_state_next = ST_TRAIL;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            ST_TRAIL: begin
                w_state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                // Swallows the data words plus the trailer of a bad stream.
                if (r_count == DRAIN_LAST) begin
                    w_count_next = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Sequencer state, counters, round-robin pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_guard <= '0;
            r_sel   <= '0;
            r_rr    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_guard <= w_guard_next;
            r_sel   <= w_sel_next;
            r_rr    <= w_rr_next;
            r_err   <= w_err_next;
        end
    end

    // One-cycle output stage; the unit tag only changes on forwarded words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout      <= '0;
            r_wr_en     <= 1'b0;
            r_pkt_start <= 1'b0;
            r_pkt_end   <= 1'b0;
            r_unit_id   <= '0;
        end else begin
            r_dout      <= w_fwd_valid ? w_word : '0;
            r_wr_en     <= w_fwd_valid;
            r_pkt_start <= w_fwd_start;
            r_pkt_end   <= w_fwd_end;
            if (w_fwd_valid) begin
                r_unit_id <= r_sel;
            end
        end
    end

    assign bus.unit_rd_en = w_rd_en;
    assign bus.dout       = r_dout;
    assign bus.wr_en      = r_wr_en;
    assign bus.pkt_start  = r_pkt_start;
    assign bus.pkt_end    = r_pkt_end;
    assign bus.unit_id    = r_unit_id;
    assign bus.err_header = r_err;

    // Only referenced to keep the tag width tied to the unit count.
    if (UNIT_W < 1) begin : g_width_guard
        initial $fatal(1, "unit index width must be positive");
    end

endmodule
`default_nettype wire

// File: tb/tb_uob_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uob_output_arbiter
// Description : Self-checking bench for uob_output_arbiter with behavioural
//               UOB models and a timing-rule reference of the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uob_output_arbiter;

    localparam int NU = 4;
    localparam int NW = 8;
    localparam int OW = 8;
    localparam int IG = NW + 4;

    logic clk;
    logic rst;

    uob_output_arbiter_if #(.N_UNITS(NU), .OUT_WIDTH(OW)) bus ();

    uob_output_arbiter #(
        .N_UNITS     (NU),
        .OUT_WIDTH   (OW),
        .OUT_N_WORDS (NW),
        .INIT_GUARD  (IG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs applied at the next cycle.
    bit rst_v   = 1'b1;
    bit space_v = 1'b1;
    int pending  [NU];
    bit bad_next [NU];

    // UOB stream models.
    bit           sact   [NU];
    int           sstart [NU];
    bit           sbad   [NU];
    logic [OW-1:0] words [NU][NW];

    // Reference of the arbiter's observable behaviour.
    int last        = 0;
    int idle_at     = 1 << 30;
    bit out_valid   = 1'b0;
    int out_start   = 0;
    int out_u       = 0;
    int err_at      = -1;
    bit err_flag    = 1'b0;
    int rst_zero_at = -1;

    int gl_u [$];
    int gl_c [$];
    int wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        logic [NU-1:0]    empty_v;
        logic [NU*OW-1:0] dv;
        logic [NU-1:0]    req;
        logic [NU-1:0]    exp_rd;
        logic [OW-1:0]    exp_d;
        int               pick;
        int               k;
        bit               exp_wr;
        @(negedge clk);
        rst       = rst_v;
        bus.space = space_v;
        if (cyc == err_at) err_flag = 1'b1;
        for (int u = 0; u < NU; u++) begin
            k = cyc - sstart[u];
            if (sact[u] && k > NW + 1) sact[u] = 1'b0;
            if (sact[u]) begin
                empty_v[u] = 1'b1;
                if (k == 0)       dv[u*OW +: OW] = sbad[u] ? 8'h00 : 8'hFF;
                else if (k <= NW) dv[u*OW +: OW] = words[u][k-1];
                else              dv[u*OW +: OW] = '0;
            end else begin
                empty_v[u] = (pending[u] == 0);
                dv[u*OW +: OW] = OW'($urandom);
            end
        end
        bus.unit_empty = empty_v;
        bus.unit_dout  = dv;
        #1;
        req    = ~empty_v;
        exp_rd = '0;
        pick   = -1;
        if (!rst_v && cyc >= idle_at && space_v && req != '0) begin
            for (int o = 1; o <= NU; o++) begin
                if (pick < 0 && req[(last + o) % NU]) pick = (last + o) % NU;
            end
            exp_rd[pick] = 1'b1;
        end
        exp_wr = out_valid && cyc >= out_start && cyc <= out_start + NW;
        if (cyc >= 1) begin
            chk("rd_en", bus.unit_rd_en, exp_rd);
            chk("wr_en", bus.wr_en, exp_wr);
            chk("pkt_start", bus.pkt_start, exp_wr && cyc == out_start);
            chk("pkt_end", bus.pkt_end, exp_wr && cyc == out_start + NW);
            chk("err_header", bus.err_header, err_flag);
            if (exp_wr) begin
                k     = cyc - out_start;
                exp_d = (k == 0) ? 8'hFF : words[out_u][k-1];
                chk("dout", bus.dout, exp_d);
                chk("unit_id", bus.unit_id, out_u);
            end
            if (cyc == rst_zero_at) begin
                chk("rst_dout", bus.dout, 0);
                chk("rst_unit_id", bus.unit_id, 0);
            end
        end
        if (bus.wr_en === 1'b1) wr_cnt++;
        for (int u = 0; u < NU; u++) begin
            if (bus.unit_rd_en[u] === 1'b1) begin
                gl_u.push_back(u);
                gl_c.push_back(cyc);
            end
        end
        if (pick >= 0) begin
            last    = pick;
            idle_at = cyc + NW + 3;
            if (bad_next[pick]) begin
                err_at = cyc + 2;
            end else begin
                out_valid = 1'b1;
                out_start = cyc + 2;
                out_u     = pick;
            end
        end
        for (int u = 0; u < NU; u++) begin
            if (bus.unit_rd_en[u] === 1'b1 && !empty_v[u]) begin
                pending[u]--;
                sact[u]     = 1'b1;
                sstart[u]   = cyc + 1;
                sbad[u]     = bad_next[u];
                bad_next[u] = 1'b0;
                for (int i = 0; i < NW; i++) words[u][i] = OW'($urandom);
            end
        end
        if (rst_v) begin
            out_valid   = 1'b0;
            err_flag    = 1'b0;
            err_at      = -1;
            last        = 0;
            idle_at     = cyc + 1 + IG;
            rst_zero_at = cyc + 1;
        end
        cyc++;
    endtask

    task automatic run_grants(input int n, input int budget, input string tag);
        int target;
        int b;
        target = gl_u.size() + n;
        b      = 0;
        while (gl_u.size() < target && b < budget) begin
            step();
            b++;
        end
        chk(tag, gl_u.size(), target);
    endtask

    initial begin
        int b;
        int w0;
        int g;
        int t0;
        for (int u = 0; u < NU; u++) begin
            pending[u]  = 0;
            bad_next[u] = 1'b0;
            sact[u]     = 1'b0;
            sstart[u]   = 0;
            sbad[u]     = 1'b0;
        end
        rst            = 1'b1;
        bus.space      = 1'b1;
        bus.unit_empty = '1;
        bus.unit_dout  = '0;

        // Reset, then a single unit granted right after the init guard.
        rst_v = 1'b1;
        repeat (3) step();
        chk("reset_wr_en", bus.wr_en, 0);
        chk("reset_err", bus.err_header, 0);
        rst_v      = 1'b0;
        pending[2] = 1;
        w0         = wr_cnt;
        run_grants(1, 40, "single_grant");
        if (gl_u.size() >= 1) begin
            chk("single_unit", gl_u[0], 2);
            chk("single_cycle", gl_c[0], 15);
        end
        repeat (12) step();
        chk("single_words", wr_cnt - w0, NW + 1);

        // Bad header on unit 3, then a good packet from the same unit.
        bad_next[3] = 1'b1;
        pending[3]  = 2;
        b  = gl_u.size();
        w0 = wr_cnt;
        run_grants(2, 40, "bad_grants");
        if (gl_u.size() >= b + 2) begin
            chk("bad_unit", gl_u[b+1], 3);
            chk("bad_spacing", gl_c[b+1] - gl_c[b], NW + 3);
        end
        repeat (12) step();
        chk("bad_words", wr_cnt - w0, NW + 1);
        chk("err_sticky", bus.err_header, 1);

        // All units busy: rotation 0,1,2,3,0 at minimum spacing.
        for (int u = 0; u < NU; u++) pending[u] = 2;
        b = gl_u.size();
        run_grants(5, 80, "busy_grants");
        space_v = 1'b0;
        for (int u = 0; u < NU; u++) pending[u] = 0;
        if (gl_u.size() >= b + 5) begin
            for (int i = 0; i < 5; i++) chk("busy_order", gl_u[b+i], i % NU);
            for (int i = 1; i < 5; i++) chk("busy_spacing", gl_c[b+i] - gl_c[b+i-1], NW + 3);
        end
        repeat (12) step();

        // Space gating.
        pending[1] = 1;
        b = gl_u.size();
        repeat (20) step();
        chk("space_hold", gl_u.size(), b);
        t0      = cyc;
        space_v = 1'b1;
        step();
        chk("space_grant", gl_u.size(), b + 1);
        if (gl_u.size() >= b + 1) begin
            chk("space_unit", gl_u[b], 1);
            chk("space_cycle", gl_c[b], t0);
        end
        repeat (12) step();

        // Wrap from pointer 3 to unit 0.
        pending[3] = 1;
        run_grants(1, 30, "wrap_pre");
        repeat (12) step();
        pending[0] = 1;
        b = gl_u.size();
        run_grants(1, 30, "wrap_grant");
        if (gl_u.size() >= b + 1) chk("wrap_unit", gl_u[b], 0);
        repeat (12) step();

        // Reset while data word 4 is on dout.
        pending[2] = 1;
        b = gl_u.size();
        run_grants(1, 30, "rst_pre");
        g = (gl_c.size() > 0) ? gl_c[gl_c.size()-1] : cyc;
        while (cyc < g + 6) step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        step();
        chk("rst_mid_wr_en", bus.wr_en, 0);
        chk("rst_mid_start", bus.pkt_start, 0);
        pending[0] = 1;
        pending[1] = 1;
        pending[3] = 1;
        b = gl_u.size();
        run_grants(1, 40, "rst_resume");
        if (gl_u.size() >= b + 1) begin
            chk("rst_resume_unit", gl_u[b], 1);
            chk("rst_resume_cycle", gl_c[b], g + 6 + IG + 1);
        end

        // Randomised traffic.
        b = gl_u.size();
        repeat (900) begin
            if ($urandom_range(0, 3) == 0) begin
                t0 = $urandom_range(0, NU - 1);
                if (pending[t0] < 3) pending[t0]++;
                if ($urandom_range(0, 7) == 0) bad_next[t0] = 1'b1;
            end
            space_v = ($urandom_range(0, 5) != 0);
            rst_v   = ($urandom_range(0, 399) == 0);
            step();
        end
        rst_v   = 1'b0;
        space_v = 1'b1;
        repeat (30) step();
        chk("random_activity", gl_u.size() > b + 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
